// File: rtl/ll_head_ctrl.sv
// ll_head_ctrl: head-pointer controller for the linked-list engine.
// Runs PUSH (new node becomes head), POP (head unlinked, head <- head.next) and CLEAR one at a
// time. It writes/reads node next-pointers in the node table, drives head-table writes and keeps
// a shadow head pointer, valid flag and list length.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o      command handshake (ready only in idle)
//   cmd_op_i, cmd_ptr_i          00 NOP, 01 PUSH, 10 POP, 11 CLEAR; node pointer for PUSH
//   node_wr_*_o                  node-table next-field write
//   node_rd_en_o/_addr_o         node-table read request
//   node_rd_next_i/_val_i        read data, valid RD_LATENCY cycles after node_rd_en_o
//   ht_wr_en_o, ht_wr_data_ptr_o, ht_wr_data_ptr_val_o   head-table write (master side)
//   resp_valid_o/_ptr_o/_err_o   one-cycle completion pulse
//   head_ptr_o, head_val_o, len_o  shadow head state and list length
module ll_head_ctrl #(
  parameter int unsigned HEAD_PTR_WIDTH = 10,
  parameter int unsigned RD_LATENCY     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [HEAD_PTR_WIDTH-1:0] cmd_ptr_i,
  output logic                      node_wr_en_o,
  output logic [HEAD_PTR_WIDTH-1:0] node_wr_addr_o,
  output logic [HEAD_PTR_WIDTH-1:0] node_wr_next_o,
  output logic                      node_wr_next_val_o,
  output logic                      node_rd_en_o,
  output logic [HEAD_PTR_WIDTH-1:0] node_rd_addr_o,
  input  logic [HEAD_PTR_WIDTH-1:0] node_rd_next_i,
  input  logic                      node_rd_next_val_i,
  output logic                      ht_wr_en_o,
  output logic [HEAD_PTR_WIDTH-1:0] ht_wr_data_ptr_o,
  output logic                      ht_wr_data_ptr_val_o,
  output logic                      resp_valid_o,
  output logic [HEAD_PTR_WIDTH-1:0] resp_ptr_o,
  output logic                      resp_err_o,
  output logic [HEAD_PTR_WIDTH-1:0] head_ptr_o,
  output logic                      head_val_o,
  output logic [HEAD_PTR_WIDTH:0]   len_o
);

  localparam int unsigned W    = HEAD_PTR_WIDTH;
  localparam int unsigned CntW = $clog2(RD_LATENCY + 1);

  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(RD_LATENCY);
  localparam logic [W:0]      LenOne = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]      LenMax = {1'b1, {W{1'b0}}};

  typedef enum logic [2:0] {
    StInit, StIdle, StPushWr, StPopRd, StPopWait, StPopUpd, StClrWr
  } state_e;

  state_e          r_state,    w_state_d;
  logic [W-1:0]    r_cmd_ptr,  w_cmd_ptr_d;
  logic [W-1:0]    r_head_ptr, w_head_ptr_d;
  logic            r_head_val, w_head_val_d;
  logic [W:0]      r_len,      w_len_d;
  logic [CntW-1:0] r_cnt,      w_cnt_d;
  logic [W-1:0]    r_nxt_ptr,  w_nxt_ptr_d;
  logic            r_nxt_val,  w_nxt_val_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= StInit;
      r_cmd_ptr  <= '0;
      r_head_ptr <= '0;
      r_head_val <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_nxt_ptr  <= '0;
      r_nxt_val  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cmd_ptr  <= w_cmd_ptr_d;
      r_head_ptr <= w_head_ptr_d;
      r_head_val <= w_head_val_d;
      r_len      <= w_len_d;
      r_cnt      <= w_cnt_d;
      r_nxt_ptr  <= w_nxt_ptr_d;
      r_nxt_val  <= w_nxt_val_d;
    end
  end

  always_comb begin
    w_state_d            = r_state;
    w_cmd_ptr_d          = r_cmd_ptr;
    w_head_ptr_d         = r_head_ptr;
    w_head_val_d         = r_head_val;
    w_len_d              = r_len;
    w_cnt_d              = r_cnt;
    w_nxt_ptr_d          = r_nxt_ptr;
    w_nxt_val_d          = r_nxt_val;
    cmd_ready_o          = 1'b0;
    node_wr_en_o         = 1'b0;
    node_wr_addr_o       = '0;
    node_wr_next_o       = '0;
    node_wr_next_val_o   = 1'b0;
    node_rd_en_o         = 1'b0;
    node_rd_addr_o       = '0;
    ht_wr_en_o           = 1'b0;
    ht_wr_data_ptr_o     = '0;
    ht_wr_data_ptr_val_o = 1'b0;
    resp_valid_o         = 1'b0;
    resp_ptr_o           = '0;
    resp_err_o           = 1'b0;

    unique case (r_state)
      StInit: begin
        // The state register sits in StInit throughout reset; gating keeps outputs at 0 then.
        ht_wr_en_o = rst_n_i;
        w_state_d  = StIdle;
      end
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_cmd_ptr_d = cmd_ptr_i;
          case (cmd_op_i)
            2'b01:   w_state_d = StPushWr;
            2'b10:   w_state_d = StPopRd;
            2'b11:   w_state_d = StClrWr;
            default: w_state_d = StIdle;
          endcase
        end
      end
      StPushWr: begin
        resp_valid_o = 1'b1;
        if (r_len == LenMax) begin
          resp_err_o = 1'b1;
        end else begin
          node_wr_en_o         = 1'b1;
          node_wr_addr_o       = r_cmd_ptr;
          node_wr_next_o       = r_head_ptr;
          node_wr_next_val_o   = r_head_val;
          ht_wr_en_o           = 1'b1;
          ht_wr_data_ptr_o     = r_cmd_ptr;
          ht_wr_data_ptr_val_o = 1'b1;
          resp_ptr_o           = r_cmd_ptr;
          w_head_ptr_d         = r_cmd_ptr;
          w_head_val_d         = 1'b1;
          w_len_d              = r_len + LenOne;
        end
        w_state_d = StIdle;
      end
      StPopRd: begin
        if (!r_head_val) begin
          resp_valid_o = 1'b1;
          resp_err_o   = 1'b1;
          w_state_d    = StIdle;
        end else begin
          node_rd_en_o   = 1'b1;
          node_rd_addr_o = r_head_ptr;
          w_cnt_d        = CntOne;
          w_state_d      = StPopWait;
        end
      end
      StPopWait: begin
        // r_cnt = cycles elapsed since the read strobe; data is valid when it hits RD_LATENCY.
        if (r_cnt == CntMax) begin
          w_nxt_ptr_d = node_rd_next_i;
          w_nxt_val_d = node_rd_next_val_i;
          w_cnt_d     = '0;
          w_state_d   = StPopUpd;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      StPopUpd: begin
        ht_wr_en_o           = 1'b1;
        ht_wr_data_ptr_o     = r_nxt_ptr;
        ht_wr_data_ptr_val_o = r_nxt_val;
        resp_valid_o         = 1'b1;
        resp_ptr_o           = r_head_ptr;
        w_head_ptr_d         = r_nxt_ptr;
        w_head_val_d         = r_nxt_val;
        if (r_len != '0) w_len_d = r_len - LenOne;
        w_state_d = StIdle;
      end
      StClrWr: begin
        ht_wr_en_o   = 1'b1;
        resp_valid_o = 1'b1;
        w_head_ptr_d = '0;
        w_head_val_d = 1'b0;
        w_len_d      = '0;
        w_state_d    = StIdle;
      end
      default: w_state_d = StInit;
    endcase
  end

  assign head_ptr_o = r_head_ptr;
  assign head_val_o = r_head_val;
  assign len_o      = r_len;

endmodule

// File: tb/tb_ll_head_ctrl.sv
// tb_ll_head_ctrl: directed bench for ll_head_ctrl with a small node-table model
// (RD_LATENCY-deep read pipeline that drives junk outside the valid cycle).
module tb_ll_head_ctrl;

  localparam int unsigned W      = 10;
  localparam int unsigned RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_ptr;
  logic          node_wr_en;
  logic [W-1:0]  node_wr_addr;
  logic [W-1:0]  node_wr_next;
  logic          node_wr_next_val;
  logic          node_rd_en;
  logic [W-1:0]  node_rd_addr;
  logic [W-1:0]  node_rd_next;
  logic          node_rd_next_val;
  logic          ht_wr_en;
  logic [W-1:0]  ht_ptr;
  logic          ht_val;
  logic          resp_valid;
  logic [W-1:0]  resp_ptr;
  logic          resp_err;
  logic [W-1:0]  head_ptr;
  logic          head_val;
  logic [W:0]    len;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ll_head_ctrl #(
    .HEAD_PTR_WIDTH (W),
    .RD_LATENCY     (RD_LAT)
  ) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .cmd_valid_i          (cmd_valid),
    .cmd_ready_o          (cmd_ready),
    .cmd_op_i             (cmd_op),
    .cmd_ptr_i            (cmd_ptr),
    .node_wr_en_o         (node_wr_en),
    .node_wr_addr_o       (node_wr_addr),
    .node_wr_next_o       (node_wr_next),
    .node_wr_next_val_o   (node_wr_next_val),
    .node_rd_en_o         (node_rd_en),
    .node_rd_addr_o       (node_rd_addr),
    .node_rd_next_i       (node_rd_next),
    .node_rd_next_val_i   (node_rd_next_val),
    .ht_wr_en_o           (ht_wr_en),
    .ht_wr_data_ptr_o     (ht_ptr),
    .ht_wr_data_ptr_val_o (ht_val),
    .resp_valid_o         (resp_valid),
    .resp_ptr_o           (resp_ptr),
    .resp_err_o           (resp_err),
    .head_ptr_o           (head_ptr),
    .head_val_o           (head_val),
    .len_o                (len)
  );

  // Node-table model: two-stage read pipeline matching RD_LAT = 2.
  logic [W-1:0] mem_next [2**W];
  logic         mem_val  [2**W];
  logic         s1_v, s2_v;
  logic [W:0]   s1_d, s2_d;

  initial begin
    for (int i = 0; i < 2**W; i++) begin
      mem_next[i] = '0;
      mem_val[i]  = 1'b0;
    end
    s1_v = 1'b0;
    s2_v = 1'b0;
    s1_d = '0;
    s2_d = '0;
  end

  always @(posedge clk) begin
    if (node_wr_en) begin
      mem_next[node_wr_addr] <= node_wr_next;
      mem_val[node_wr_addr]  <= node_wr_next_val;
    end
    s1_v <= node_rd_en;
    s1_d <= {mem_val[node_rd_addr], mem_next[node_rd_addr]};
    s2_v <= s1_v;
    s2_d <= s1_d;
  end

  assign node_rd_next     = s2_v ? s2_d[W-1:0] : 10'h3aa;
  assign node_rd_next_val = s2_v ? s2_d[W]     : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command in the current (idle) cycle; returns at the negedge of cycle t+1.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] ptr);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ptr   = ptr;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_ptr   = '0;
  endtask

  task automatic push_full(input logic [W-1:0] ptr, input logic [W-1:0] exp_nxt,
                           input logic exp_nval, input int exp_len);
    issue(2'b01, ptr);
    chk("push_resp_valid", resp_valid, 1);
    chk("push_resp_err", resp_err, 0);
    chk("push_resp_ptr", resp_ptr, ptr);
    chk("push_node_wr_en", node_wr_en, 1);
    chk("push_node_addr", node_wr_addr, ptr);
    chk("push_node_next", node_wr_next, exp_nxt);
    chk("push_node_nval", node_wr_next_val, exp_nval);
    chk("push_ht_wr_en", ht_wr_en, 1);
    chk("push_ht_ptr", ht_ptr, ptr);
    chk("push_ht_val", ht_val, 1);
    chk("push_ready_busy", cmd_ready, 0);
    @(negedge clk);
    chk("push_head_ptr", head_ptr, ptr);
    chk("push_head_val", head_val, 1);
    chk("push_len", len, exp_len);
    chk("push_ht_idle", ht_wr_en, 0);
  endtask

  task automatic pop_full(input logic [W-1:0] exp_old, input logic [W-1:0] exp_nxt,
                          input logic exp_nval, input int exp_len);
    issue(2'b10, '0);
    chk("pop_rd_en", node_rd_en, 1);
    chk("pop_rd_addr", node_rd_addr, exp_old);
    chk("pop_t1_resp", resp_valid, 0);
    chk("pop_t1_ht", ht_wr_en, 0);
    @(negedge clk);
    chk("pop_t2_rd_en", node_rd_en, 0);
    chk("pop_t2_resp", resp_valid, 0);
    @(negedge clk);
    chk("pop_t3_resp", resp_valid, 0);
    @(negedge clk);
    chk("pop_resp_valid", resp_valid, 1);
    chk("pop_resp_err", resp_err, 0);
    chk("pop_resp_ptr", resp_ptr, exp_old);
    chk("pop_ht_wr_en", ht_wr_en, 1);
    chk("pop_ht_ptr", ht_ptr, exp_nxt);
    chk("pop_ht_val", ht_val, exp_nval);
    @(negedge clk);
    chk("pop_resp_done", resp_valid, 0);
    chk("pop_len", len, exp_len);
    chk("pop_head_ptr", head_ptr, exp_nxt);
    chk("pop_head_val", head_val, exp_nval);
    chk("pop_ready", cmd_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_ptr   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ht_wr_en", ht_wr_en, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_len", len, 0);
    chk("rst_head_val", head_val, 0);
    chk("rst_resp_valid", resp_valid, 0);

    // Release away from the clock edge; INIT write is visible in the first cycle.
    rst_n = 1'b1;
    #1;
    chk("init_ht_wr_en", ht_wr_en, 1);
    chk("init_ht_val", ht_val, 0);
    chk("init_ht_ptr", ht_ptr, 0);
    chk("init_ready", cmd_ready, 0);
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_ht_wr_en", ht_wr_en, 0);
    chk("idle_len", len, 0);

    push_full(10'd5, 10'd0, 1'b0, 1);
    push_full(10'd9, 10'd5, 1'b1, 2);
    pop_full(10'd9, 10'd5, 1'b1, 1);
    pop_full(10'd5, 10'd0, 1'b0, 0);

    // POP on empty list
    issue(2'b10, '0);
    chk("pope_resp_valid", resp_valid, 1);
    chk("pope_resp_err", resp_err, 1);
    chk("pope_rd_en", node_rd_en, 0);
    chk("pope_ht_wr_en", ht_wr_en, 0);
    chk("pope_node_wr_en", node_wr_en, 0);
    @(negedge clk);
    chk("pope_ready", cmd_ready, 1);
    chk("pope_len", len, 0);

    // NOP is dropped without a response
    issue(2'b00, 10'd77);
    chk("nop_resp_valid", resp_valid, 0);
    chk("nop_ready", cmd_ready, 1);
    chk("nop_ht_wr_en", ht_wr_en, 0);

    // Fill to 2**W
    for (int i = 0; i < 2**W; i++) begin
      issue(2'b01, W'(i));
      chk("fill_resp_err", resp_err, 0);
      @(negedge clk);
    end
    chk("full_len", len, 2**W);
    chk("full_head_ptr", head_ptr, 2**W - 1);

    issue(2'b01, 10'd7);
    chk("ovf_resp_valid", resp_valid, 1);
    chk("ovf_resp_err", resp_err, 1);
    chk("ovf_node_wr_en", node_wr_en, 0);
    chk("ovf_ht_wr_en", ht_wr_en, 0);
    @(negedge clk);
    chk("ovf_len", len, 2**W);
    chk("ovf_head_ptr", head_ptr, 2**W - 1);

    issue(2'b11, 10'd33);
    chk("clr_ht_wr_en", ht_wr_en, 1);
    chk("clr_ht_ptr", ht_ptr, 0);
    chk("clr_ht_val", ht_val, 0);
    chk("clr_resp_valid", resp_valid, 1);
    chk("clr_resp_ptr", resp_ptr, 0);
    chk("clr_node_wr_en", node_wr_en, 0);
    @(negedge clk);
    chk("clr_len", len, 0);
    chk("clr_head_val", head_val, 0);
    chk("clr_head_ptr", head_ptr, 0);

    // Reset in the middle of a POP
    push_full(10'd3, 10'd0, 1'b0, 1);
    push_full(10'd4, 10'd3, 1'b1, 2);
    issue(2'b10, '0);
    chk("rpop_rd_en", node_rd_en, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rpop_ready", cmd_ready, 0);
    chk("rpop_ht_wr_en", ht_wr_en, 0);
    chk("rpop_len", len, 0);
    chk("rpop_head_val", head_val, 0);
    @(negedge clk);
    chk("rpop_stale_resp", resp_valid, 0);
    chk("rpop_stale_ht", ht_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rinit_ht_wr_en", ht_wr_en, 1);
    chk("rinit_ht_val", ht_val, 0);
    @(negedge clk);
    chk("rinit_ready", cmd_ready, 1);
    chk("rinit_resp_valid", resp_valid, 0);
    chk("rinit_len", len, 0);
    chk("rinit_head_val", head_val, 0);
    repeat (3) @(negedge clk);
    chk("rinit_quiet_ht", ht_wr_en, 0);
    chk("rinit_quiet_resp", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
